// File: rtl/toggle_decoder.sv
// Toggle-level event decoder: synchronizes a toggled level, turns each level
// change into a one-cycle pulse, and queues events for a valid/ready consumer.
module toggle_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_i,
  input  logic             ready_i,
  output logic             pulse_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] pending_o,
  output logic [CNT_W-1:0] total_o,
  output logic             overflow_o
);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX   = '1;
  localparam logic [CNT_W-1:0] PEND_ONE   = CNT_W'(1);
  localparam logic [2:0]       PRIME_LAST = 3'(SYNC_STAGES);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref_q;
  logic [2:0]             r_prime_cnt;
  logic                   r_pulse;
  logic [CNT_W-1:0]       r_pending;
  logic [CNT_W-1:0]       r_total;
  logic                   r_overflow;

  logic w_sync_q;
  logic w_trans;
  logic w_hs;
  logic w_prime_done;
  logic w_pend_full;
  logic w_pend_one;

  // Handshake: an event is transferred on a rising edge where valid_o and
  // ready_i are both high; ready_i has no effect while valid_o is low.
  assign w_sync_q     = r_sync[SYNC_STAGES-1];
  assign w_trans      = (r_state != ST_PRIME) && (w_sync_q != r_ref_q);
  assign w_hs         = valid_o && ready_i;
  assign w_prime_done = (r_prime_cnt == PRIME_LAST);
  assign w_pend_full  = (r_pending == PEND_MAX);
  assign w_pend_one   = (r_pending == PEND_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], q_i};
    end
  end

  // ref_q tracks sync_q every cycle, both while priming and after a detection,
  // so back-to-back toggles each produce their own pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_q     <= 1'b0;
      r_prime_cnt <= '0;
    end else begin
      r_ref_q <= w_sync_q;
      if (r_state == ST_PRIME) begin
        r_prime_cnt <= r_prime_cnt + 3'd1;
      end else begin
        r_prime_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PRIME: if (w_prime_done) w_state_nxt = ST_IDLE;
      ST_IDLE:  if (w_trans) w_state_nxt = ST_PEND;
      ST_PEND:  if (w_hs && !w_trans && w_pend_one) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_PRIME;
    endcase
  end

  always_comb begin
    valid_o = 1'b0;
    case (r_state)
      ST_PEND: valid_o = 1'b1;
      default: valid_o = 1'b0;
    endcase
  end

  // A transition arriving at saturation with no handshake is dropped from the
  // queue but still counted in total_o and flagged in overflow_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse    <= 1'b0;
      r_pending  <= '0;
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pulse <= w_trans;
      if (w_trans) begin
        r_total <= r_total + PEND_ONE;
      end
      if (w_trans && !w_hs) begin
        if (w_pend_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_pending <= r_pending + PEND_ONE;
        end
      end else if (!w_trans && w_hs) begin
        r_pending <= r_pending - PEND_ONE;
      end
    end
  end

  assign pulse_o    = r_pulse;
  assign pending_o  = r_pending;
  assign total_o    = r_total;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed and random checks of toggle_decoder against a history-based model
// of decoded events and an integer model of the event queue.
module tb_toggle_decoder;

  localparam int S    = 2;
  localparam int W    = 4;
  localparam int PMAX = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         q_i;
  logic         ready_i;
  logic         pulse_o;
  logic         valid_o;
  logic [W-1:0] pending_o;
  logic [W-1:0] total_o;
  logic         overflow_o;

  int tests_run;
  int tests_failed;

  // model state: hist[k] is the q_i level sampled by edge k after reset release
  logic hist[$];
  int   k;
  int   pend_m;
  int   tot_m;
  bit   ovf_m;

  toggle_decoder #(.SYNC_STAGES(S), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_i        (q_i),
    .ready_i    (ready_i),
    .pulse_o    (pulse_o),
    .valid_o    (valid_o),
    .pending_o  (pending_o),
    .total_o    (total_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pulse"},    32'(pulse_o),    32'(pulse_m()));
    check({tag, ".valid"},    32'(valid_o),    32'(pend_m > 0));
    check({tag, ".pending"},  32'(pending_o),  32'(pend_m));
    check({tag, ".total"},    32'(total_o),    32'(tot_m));
    check({tag, ".overflow"}, 32'(overflow_o), 32'(ovf_m));
  endtask

  // Event decoded by edge k: the level sampled S edges earlier differs from the
  // one before it, and the first S+1 edges after release are priming.
  function automatic bit pulse_m();
    if (k < S + 2) return 1'b0;
    return hist[k-S] != hist[k-S-1];
  endfunction

  task automatic step(input logic q, input logic rdy, input string tag);
    bit ev;
    bit hs;
    q_i     = q;
    ready_i = rdy;
    hs      = (pend_m > 0) && rdy;
    @(posedge clk);
    hist.push_back(q);
    k++;
    ev = pulse_m();
    if (ev) tot_m = (tot_m + 1) % (PMAX + 1);
    if (ev && !hs) begin
      if (pend_m == PMAX) ovf_m = 1'b1;
      else pend_m++;
    end else if (!ev && hs) begin
      pend_m--;
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input logic q_hold);
    q_i     = q_hold;
    ready_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst.pulse",    32'(pulse_o),    32'd0);
    check("rst.valid",    32'(valid_o),    32'd0);
    check("rst.pending",  32'(pending_o),  32'd0);
    check("rst.total",    32'(total_o),    32'd0);
    check("rst.overflow", 32'(overflow_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hist.delete();
    hist.push_back(q_hold);
    k      = 0;
    pend_m = 0;
    tot_m  = 0;
    ovf_m  = 1'b0;
  endtask

  initial begin
    logic lvl;
    tests_run    = 0;
    tests_failed = 0;
    rst_n   = 1'b0;
    q_i     = 1'b0;
    ready_i = 1'b0;
    #3;

    // q_i high through release must not decode as an event
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "prime_hold");
    check("prime_hold.total_end", 32'(total_o), 32'd0);

    // single toggle, pulse three edges later, then one handshake
    lvl = 1'b0;
    step(lvl, 1'b0, "single.t0");
    check("single.no_pulse_e1", 32'(pulse_o), 32'd0);
    step(lvl, 1'b0, "single.t1");
    check("single.no_pulse_e2", 32'(pulse_o), 32'd0);
    step(lvl, 1'b0, "single.t2");
    check("single.pulse_e3", 32'(pulse_o), 32'd1);
    check("single.pending1", 32'(pending_o), 32'd1);
    check("single.total1",   32'(total_o),   32'd1);
    step(lvl, 1'b1, "single.hs");
    check("single.pending0", 32'(pending_o), 32'd0);
    check("single.valid0",   32'(valid_o),   32'd0);

    // toggle every cycle for 4 cycles
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "burst.prime");
    lvl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lvl = ~lvl;
      step(lvl, 1'b0, "burst.tog");
    end
    for (int i = 0; i < 4; i++) step(lvl, 1'b0, "burst.settle");
    check("burst.pending4", 32'(pending_o), 32'd4);
    check("burst.total4",   32'(total_o),   32'd4);

    // simultaneous decode and handshake at pending 2
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "simul.prime");
    step(1'b1, 1'b0, "simul.a");
    step(1'b0, 1'b0, "simul.b");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "simul.settle");
    check("simul.pending2_pre", 32'(pending_o), 32'd2);
    step(1'b1, 1'b0, "simul.c0");
    step(1'b1, 1'b0, "simul.c1");
    step(1'b1, 1'b1, "simul.c2");
    check("simul.pending2_hold", 32'(pending_o), 32'd2);
    step(1'b1, 1'b1, "simul.drain1");
    check("simul.pending1", 32'(pending_o), 32'd1);
    step(1'b1, 1'b1, "simul.drain0");
    check("simul.pending0", 32'(pending_o), 32'd0);
    step(1'b1, 1'b1, "simul.ignored_ready");

    // 17 toggles saturate pending and wrap total
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "sat.prime");
    lvl = 1'b0;
    for (int i = 0; i < 17; i++) begin
      lvl = ~lvl;
      step(lvl, 1'b0, "sat.tog");
    end
    for (int i = 0; i < 4; i++) step(lvl, 1'b0, "sat.settle");
    check("sat.pending15", 32'(pending_o),  32'd15);
    check("sat.overflow",  32'(overflow_o), 32'd1);
    check("sat.total1",    32'(total_o),    32'd1);
    for (int i = 0; i < 15; i++) step(lvl, 1'b1, "sat.drain");
    check("sat.drained",     32'(pending_o),  32'd0);
    check("sat.ovf_sticky",  32'(overflow_o), 32'd1);

    // asynchronous reset with pending 3, then a quiet priming window
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "mid.prime");
    lvl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lvl = ~lvl;
      step(lvl, 1'b0, "mid.tog");
    end
    for (int i = 0; i < 3; i++) step(lvl, 1'b0, "mid.settle");
    check("mid.pending3", 32'(pending_o), 32'd3);
    do_reset(~lvl);
    for (int i = 0; i < S + 1; i++) begin
      step(~lvl, 1'b0, "mid.after");
      check("mid.no_pulse", 32'(pulse_o), 32'd0);
    end

    // random levels and ready against the model
    do_reset(1'b0);
    lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 55) lvl = ~lvl;
      step(lvl, 1'($urandom_range(0, 99) < 30), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/toggle_decoder.md
TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on q_i (legal range 2..4).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the pending and total event counters (legal range 2..16).
REQ-003 Port clk SHALL be: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n SHALL be: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port q_i SHALL be: q_i  input  1  toggled level from a toggler; each level change encodes one event.
REQ-006 Port ready_i SHALL be: ready_i  input  1  consumer accepts one event when high with valid_o high.
REQ-007 Port pulse_o SHALL be: pulse_o  output  1  one-cycle pulse per decoded transition.
REQ-008 Port valid_o SHALL be: valid_o  output  1  at least one event pending.
REQ-009 Port pending_o SHALL be: pending_o  output  CNT_W  number of events not yet accepted.
REQ-010 Port total_o SHALL be: total_o  output  CNT_W  decoded events since reset, modulo 2^CNT_W.
REQ-011 Port overflow_o SHALL be: overflow_o  output  1  sticky flag; an event was lost at pending saturation.

Function
REQ-012 q_i SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync_q) is used downstream.
REQ-013 A reference register ref_q SHALL hold the previously decoded level; a transition is detected when sync_q != ref_q, and ref_q then loads sync_q on the same edge.
REQ-014 pulse_o SHALL be registered and high for exactly one cycle, first visible SYNC_STAGES+1 rising edges after the edge that first samples the new q_i level.
REQ-015 A level change on q_i on every cycle SHALL yield one pulse_o per cycle; no transition may be merged or dropped by the detector.
REQ-016 The FSM SHALL have states PRIME, IDLE and PEND.
REQ-017 PRIME SHALL be entered at reset and last exactly SYNC_STAGES+1 cycles; ref_q SHALL load sync_q every cycle, no transition is decoded, and the FSM then goes to IDLE.
REQ-018 In IDLE, valid_o SHALL be 0; a decoded transition SHALL move the FSM to PEND with pending_o = 1.
REQ-019 In PEND, valid_o SHALL be 1; a handshake is valid_o && ready_i on a rising edge.
REQ-020 pending_o SHALL increment on a decoded transition, decrement on a handshake, and remain unchanged when both occur on the same edge.
REQ-021 A handshake with pending_o = 1 and no simultaneous transition SHALL return the FSM to IDLE on that edge; otherwise the FSM SHALL stay in PEND.
REQ-022 pending_o SHALL saturate at 2^CNT_W-1; a transition at saturation without a simultaneous handshake SHALL be lost, SHALL still pulse pulse_o and increment total_o, and SHALL set overflow_o.
REQ-023 overflow_o SHALL remain set until reset.
REQ-024 total_o SHALL increment on every decoded transition and wrap from 2^CNT_W-1 to 0.
REQ-025 ready_i SHALL be ignored while valid_o is 0.

Reset
REQ-026 While rst_n is 0, all flops (synchronizer, ref_q, FSM, counters) SHALL be cleared immediately: pulse_o=0, valid_o=0, pending_o=0, total_o=0, overflow_o=0, and the FSM SHALL be in PRIME.
REQ-027 Reset asserted mid-operation SHALL discard all pending events; after release the FSM SHALL re-prime, so a q_i level of 1 held through release SHALL NOT produce an event.

Verification
REQ-028 Scenario: rst_n released with q_i=1 held for 10 cycles -> pulse_o never high; total_o=0; valid_o=0.
REQ-029 Scenario: after priming, q_i toggles once, ready_i=0 -> one pulse_o 3 cycles later; pending_o=1, valid_o=1, total_o=1; then ready_i=1 for 1 cycle -> pending_o=0, valid_o=0.
REQ-030 Scenario: q_i toggles every cycle for 4 cycles, ready_i=0 -> 4 consecutive pulse_o cycles; pending_o=4, total_o=4.
REQ-031 Scenario: ready_i=1 held with pending_o=2 while one new transition is decoded -> pending_o stays 2 on that edge, then drains 1 per cycle to 0.
REQ-032 Scenario: CNT_W=4, 17 toggles with ready_i=0 -> pending_o=15, overflow_o=1, total_o=1 (wrapped); drain 15 handshakes -> pending_o=0, overflow_o still 1.
REQ-033 Scenario: rst_n pulsed low with pending_o=3 -> all outputs 0 asynchronously, no pulse for SYNC_STAGES+1 cycles after release.
